// File: rtl/isqrt_seq_pkg.sv
// isqrt_seq_pkg: shared widths, state encoding and iteration count for the sequential isqrt
package isqrt_seq_pkg;
  localparam int X_W = 32;
  localparam int Y_W = 16;
  localparam int REM_W = 18;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic int n_iter(input int roots_per_cycle);
    return Y_W / roots_per_cycle;
  endfunction
endpackage

// File: rtl/isqrt_seq_step.sv
// isqrt_seq_step: one combinational restoring square-root step
// rem_i/root_i: partial remainder and root in; bits_i: next two radicand bits (MSB first)
// rem_o/root_o: updated remainder and root with one more result bit appended
module isqrt_seq_step
  import isqrt_seq_pkg::*;
(
  input  logic [REM_W-1:0] rem_i,
  input  logic [Y_W-1:0]   root_i,
  input  logic [1:0]       bits_i,
  output logic [REM_W-1:0] rem_o,
  output logic [Y_W-1:0]   root_o
);
  logic [REM_W-1:0] rem_s;
  logic [REM_W-1:0] trial;
  logic ge;
  always_comb begin
    rem_s  = REM_W'({rem_i, bits_i});
    trial  = {root_i, 2'b01};
    ge     = rem_s >= trial;
    rem_o  = ge ? rem_s - trial : rem_s;
    root_o = {root_i[Y_W-2:0], ge};
  end
endmodule

// File: rtl/isqrt_seq_fsm.sv
// isqrt_seq_fsm: multi-cycle floor(sqrt(x)) responder, ROOTS_PER_CYCLE result bits per clock
// clk/rst: clock, async active-high reset; x_vld/x: request strobe and radicand
// y_vld/y: one-cycle result strobe and held result; busy: high while computing (requests ignored)
module isqrt_seq_fsm
  import isqrt_seq_pkg::*;
#(
  parameter int ROOTS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [X_W-1:0] x,
  output logic           y_vld,
  output logic [Y_W-1:0] y,
  output logic           busy
);
  localparam int N = n_iter(ROOTS_PER_CYCLE);
  localparam int CNT_W = 5;
  if (!(ROOTS_PER_CYCLE == 1 || ROOTS_PER_CYCLE == 2 || ROOTS_PER_CYCLE == 4 ||
        ROOTS_PER_CYCLE == 8 || ROOTS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("ROOTS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  state_e state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [Y_W-1:0]   root_q, root_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, calc, last;
  logic [REM_W-1:0] rem_c [ROOTS_PER_CYCLE+1];
  logic [Y_W-1:0]   root_c [ROOTS_PER_CYCLE+1];
  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;
  // Chain of steps consumes the top 2*ROOTS_PER_CYCLE radicand bits each CALC cycle
  for (genvar s = 0; s < ROOTS_PER_CYCLE; s++) begin : g_step
    isqrt_seq_step u_step (
      .rem_i (rem_c[s]),
      .root_i(root_c[s]),
      .bits_i(x_q[X_W-1-2*s -: 2]),
      .rem_o (rem_c[s+1]),
      .root_o(root_c[s+1])
    );
  end
  always_comb begin
    calc    = state_q == CALC;
    accept  = x_vld && !calc;
    last    = calc && cnt_q == CNT_W'(N - 1);
    state_d = accept ? CALC : calc ? (last ? DONE : CALC) : IDLE;
    x_d     = accept ? x : calc ? x_q << (2 * ROOTS_PER_CYCLE) : x_q;
    rem_d   = accept ? '0 : calc ? rem_c[ROOTS_PER_CYCLE] : rem_q;
    root_d  = accept ? '0 : calc ? root_c[ROOTS_PER_CYCLE] : root_q;
    cnt_d   = accept ? '0 : calc ? cnt_q + 1'b1 : cnt_q;
    y_d     = last ? root_c[ROOTS_PER_CYCLE] : y_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end
  assign y     = y_q;
  assign y_vld = state_q == DONE;
  assign busy  = state_q == CALC;
endmodule

// File: tb/tb_isqrt_seq_fsm.sv
// tb_isqrt_seq_fsm: random and directed checks of three isqrt_seq_fsm instances (R=1,4,16) against a timing/result model
module tb_isqrt_seq_fsm;
  logic clk = 0;
  logic rst = 1;
  logic        x_vld [3];
  logic [31:0] x     [3];
  logic        y_vld [3];
  logic [15:0] y     [3];
  logic        busy  [3];
  int n_vec = 0;
  int n_err = 0;
  int          left  [3] = '{0, 0, 0};
  logic [15:0] pend  [3] = '{0, 0, 0};
  logic [15:0] ey    [3] = '{0, 0, 0};
  logic        ev    [3] = '{0, 0, 0};
  int          acc_n [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    isqrt_seq_fsm #(.ROOTS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 4 : 16)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .x_vld(x_vld[g]),
      .x    (x[g]),
      .y_vld(y_vld[g]),
      .y    (y[g]),
      .busy (busy[g])
    );
  end

  function automatic int nit(input int i);
    return 16 / (i == 0 ? 1 : i == 1 ? 4 : 16);
  endfunction

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint vv = longint'(v);
    longint r = longint'($sqrt(real'(vv)));
    while (r * r > vv) r--;
    while ((r + 1) * (r + 1) <= vv) r++;
    return 16'(r);
  endfunction

  function automatic logic [31:0] rnd_x();
    int m = $urandom_range(0, 7);
    logic [31:0] r = 32'($urandom_range(1, 65535));
    case (m)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return r * r;
      3: return r * r - 1;
      4: return r * r + 2 * r;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a request accepted while not busy occupies N cycles, then the result strobes for one cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        left[i] <= 0;
        ev[i]   <= 0;
        ey[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        ev[i] <= left[i] == 1;
        if (left[i] == 1) ey[i] <= pend[i];
        if (x_vld[i] && left[i] == 0) begin
          left[i]  <= nit(i);
          pend[i]  <= isqrt(x[i]);
          acc_n[i] <= acc_n[i] + 1;
        end else if (left[i] > 0) left[i] <= left[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("y_vld[%0d]", i), longint'(y_vld[i]), longint'(ev[i]));
      chk($sformatf("busy[%0d]", i), longint'(busy[i]), longint'(left[i] > 0));
      chk($sformatf("y[%0d]", i), longint'(y[i]), longint'(ey[i]));
    end
  end

  task automatic req(input int i, input logic [31:0] xv, input logic [15:0] yexp, input int lat_exp);
    int lat = 0;
    x_vld[i] = 1;
    x[i] = xv;
    do begin
      @(negedge clk);
      x_vld[i] = 0;
      lat++;
    end while (!y_vld[i] && lat < 100);
    chk($sformatf("lat[%0d] x=%0h", i, xv), lat, lat_exp);
    chk($sformatf("res[%0d] x=%0h", i, xv), longint'(y[i]), longint'(yexp));
  endtask

  task automatic rand_run(input int i);
    int cyc = 0;
    int base = acc_n[i];
    int lim = 2200 * (nit(i) + 1);
    while (acc_n[i] - base < 1000 && cyc < lim) begin
      x_vld[i] = $urandom_range(0, 3) != 0;
      x[i] = rnd_x();
      @(negedge clk);
      cyc++;
    end
    x_vld[i] = 0;
    chk($sformatf("rand_count[%0d]", i), longint'(acc_n[i] - base >= 1000), 1);
  endtask

  initial begin
    int pulses;
    logic [15:0] ylast;
    for (int i = 0; i < 3; i++) begin
      x_vld[i] = 0;
      x[i] = 0;
    end
    chk("model_16", longint'(isqrt(32'd16)), 4);
    chk("model_15", longint'(isqrt(32'd15)), 3);
    chk("model_max", longint'(isqrt(32'hFFFF_FFFF)), 'hFFFF);
    chk("model_fffe0000", longint'(isqrt(32'hFFFE_0000)), 'hFFFE);
    repeat (3) @(negedge clk);
    chk("rst_y_vld", longint'(y_vld[0]), 0);
    chk("rst_busy", longint'(busy[0]), 0);
    chk("rst_y", longint'(y[0]), 0);
    rst = 0;
    repeat (4) @(negedge clk);
    req(0, 32'd16, 16'd4, 17);
    req(0, 32'd0, 16'd0, 17);
    req(0, 32'd15, 16'd3, 17);
    req(0, 32'hFFFF_FFFF, 16'hFFFF, 17);
    req(0, 32'hFFFE_0001, 16'hFFFF, 17);
    req(0, 32'hFFFE_0000, 16'hFFFE, 17);
    req(0, 32'd49, 16'd7, 17);
    req(0, 32'd100, 16'd10, 17);
    @(negedge clk);
    x_vld[0] = 1;
    x[0] = 81;
    @(negedge clk);
    x_vld[0] = 0;
    @(negedge clk);
    @(negedge clk);
    x_vld[0] = 1;
    x[0] = 4;
    chk("busy_during_ignore", longint'(busy[0]), 1);
    @(negedge clk);
    x_vld[0] = 0;
    pulses = 0;
    ylast = 0;
    repeat (30) begin
      @(negedge clk);
      if (y_vld[0]) begin
        pulses++;
        ylast = y[0];
      end
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_y", longint'(ylast), 9);
    x_vld[0] = 1;
    x[0] = 1000000;
    @(negedge clk);
    x_vld[0] = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_y_vld", longint'(y_vld[0]), 0);
    chk("arst_busy", longint'(busy[0]), 0);
    chk("arst_y", longint'(y[0]), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (y_vld[0]) pulses++;
    end
    chk("arst_no_pulse", pulses, 0);
    req(0, 32'd1000000, 16'd1000, 17);
    req(1, 32'd1000000, 16'd1000, 5);
    req(1, 32'hFFFF_FFFF, 16'hFFFF, 5);
    req(2, 32'hFFFF_FFFF, 16'hFFFF, 2);
    req(2, 32'd0, 16'd0, 2);
    req(2, 32'd16, 16'd4, 2);
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/isqrt_seq_fsm.md
Name: isqrt_seq_fsm

Overview:
Multi-cycle integer square root responder, the serving end of the isqrt request/response interface that the formula FSMs drive (x_vld/x in, y_vld/y out). It computes y = floor(sqrt(x)) for a 32-bit unsigned x using digit-by-digit restoring iterations, ROOTS_PER_CYCLE result bits per clock. It is an area-saving drop-in wherever a formula FSM waits on y_vld and issues no new request while waiting.

Parameters:
ROOTS_PER_CYCLE, 1, result bits resolved per clock; legal values 1, 2, 4, 8, 16; other values are a compile-time error.

Ports:
clk  input  1  clock, all flops on rising edge
rst  input  1  reset; asynchronous, active-high
x_vld  input  1  request strobe, one cycle per request
x  input  32  unsigned radicand, sampled only when the request is accepted
y_vld  output  1  result strobe, high for exactly one cycle per accepted request
y  output  16  floor(sqrt(x)); registered, holds the last result until the next result
busy  output  1  high while a request is in flight (state CALC); x_vld is not accepted while busy=1

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, y_vld=0, y=0, busy=0, and iteration counter, remainder and root registers cleared. Any in-flight request is dropped and no y_vld is produced for it. The first request is accepted on the first clk edge after rst deasserts.
- N = 16 / ROOTS_PER_CYCLE iterations.
- States:
  - IDLE: y_vld=0, busy=0. x_vld=1 -> latch x, clear remainder, root and counter; go to CALC.
  - CALC: busy=1. Each cycle performs ROOTS_PER_CYCLE restoring steps and increments the counter. After the Nth CALC cycle, go to DONE. x_vld in CALC is ignored: no latch, no error, no queuing.
  - DONE: y_vld=1, busy=0, y already holds the final root. x_vld=1 -> accept, latch x, go to CALC (back-to-back). Otherwise go to IDLE.
- Latency: a request on cycle T produces y_vld on cycle T+N+1. Examples: R=1 gives 17; R=16 gives 2.
- Throughput: one result every N+1 cycles with back-to-back requests accepted in DONE.
- y update rule: y is written only on the transition into DONE. It is stable during CALC and IDLE, and keeps the previous result until the next result.
- Restoring step, per bit i from MSB:
  - rem' = (rem << 2) | next two x bits
  - trial = (root << 2) | 1
  - if rem' >= trial: rem = rem' - trial and root = (root << 1) | 1; else rem = rem' and root = root << 1.
- Widths:
  - rem: 18 bits, unsigned compare, no sign bit.
  - root: 16 bits.
  - x shift register: 32 bits, consumed 2 bits per step, MSB first.
- Boundaries:
  - x=0 yields 0.
  - x=0xFFFFFFFF yields 0xFFFF; the remainder must not overflow at 18 bits.
  - Perfect squares are exact; non-squares truncate.

Decomposition:
- Package isqrt_seq_pkg holds:
  - state enum (IDLE, CALC, DONE; 2-bit)
  - localparams X_W=32, Y_W=16, REM_W=18
  - function n_iter(roots_per_cycle)
- Sub-module isqrt_seq_step: purely combinational single restoring step (inputs rem, root, 2 radicand bits; outputs rem, root). It is generated ROOTS_PER_CYCLE times in a chain inside the CALC datapath.

Test Plan:
- R=1, x=16 at cycle 5 -> y_vld only at cycle 22, y=4; x=0 -> y=0; x=15 -> y=3.
- x=0xFFFFFFFF -> y=0xFFFF; x=0xFFFE0001 -> y=0xFFFF; x=0xFFFE0000 -> y=0xFFFE.
- x_vld=1 with x=100 in the DONE cycle of a prior x=49 request -> y=7 pulse, then y=10 exactly 17 cycles later, with no IDLE gap.
- x=81 accepted, then x_vld with x=4 three cycles later (busy=1) -> single y_vld with y=9; the second request is ignored and no second y_vld appears.
- rst asserted asynchronously mid-CALC, x=1000000 -> y_vld, y and busy go 0 immediately; no y_vld after release; a new x=1000000 gives y=1000.
- Repeat the 1000-vector random compare against floor(sqrt) for R in {1, 4, 16}; check latency N+1 and busy timing for each.
